cal_scheduler: RTL



---
 rtl/cal_sched_pkg.sv | 33 +++
 rtl/cal_sched_fifo.sv | 59 +++++
 rtl/cal_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cal_sched_pkg.sv
// Shared types and constants for the calibration command scheduler.
// Optional statistics counters in cal_scheduler are enabled by CAL_SCHED_STATS_EN.
package cal_sched_pkg;

  localparam int CAL_PAYLOAD_W = 20;
  localparam int CAL_BCAST_BIT = 19;
  localparam int CAL_WAIT_W    = 7;

  typedef struct packed {
    logic       edgeMode;
    logic [2:0] edgeDly;
    logic [5:0] edgeWidth;
    logic       auxMode;
    logic [4:0] auxDly;
  } cal_fields_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GUARD = 2'd2
  } cal_sched_state_t;

  // Injection length: the longer of the edge path and the aux path.
  // Worst case is 7*4 + 63 + 4 = 95, so 7 bits never wrap.
  function automatic logic [CAL_WAIT_W-1:0] calWaitCycles(input cal_fields_t f);
    logic [CAL_WAIT_W-1:0] edgeTerm;
    logic [CAL_WAIT_W-1:0] auxTerm;
    edgeTerm = {2'b00, f.edgeDly, 2'b00} + {1'b0, f.edgeWidth} + 7'd4;
    auxTerm  = {2'b00, f.auxDly} + 7'd3;
    return (edgeTerm > auxTerm) ? edgeTerm : auxTerm;
  endfunction

endpackage

// File: rtl/cal_sched_fifo.sv
// Synchronous FIFO of pending calibration field words.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module cal_sched_fifo import cal_sched_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  cal_fields_t              wrData,
  output cal_fields_t              rdData,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     pushDropped
);

  localparam int AW = $clog2(DEPTH);

  cal_fields_t         mem [DEPTH];
  logic [AW-1:0]       wrPtr;
  logic [AW-1:0]       rdPtr;
  logic [AW:0]         count;
  logic                doPush;
  logic                doPop;

  assign empty       = (count == '0);
  assign full        = (count == (AW+1)'(DEPTH));
  assign doPop       = pop && !empty;
  assign doPush      = push && (!full || doPop);
  assign pushDropped = push && full && !doPop;
  assign rdData      = mem[rdPtr];
  assign level       = count;

  // Storage array; no reset needed since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (doPush && !Reset) begin
      mem[wrPtr] <= wrData;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cal_scheduler.sv
// Calibration command scheduler: filters Cal commands by chip ID, queues them
// and issues one GenCal at a time, spacing issues by injection time plus guard.
// Define CAL_SCHED_STATS_EN to add the CalIssueCnt / DropCnt statistics ports.
//
// state | meaning
// IDLE  | waiting for a queued command; issues GenCal combinationally when one is present
// RUN   | injection in progress, waitCnt counts down to 0 (waitCnt+1 cycles)
// GUARD | guard interval after injection, HOLDOFF cycles
module cal_scheduler import cal_sched_pkg::*; #(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 8
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       CalValid,
  input  logic [CAL_PAYLOAD_W-1:0]   CalPayload,
  input  logic [2:0]                 ChipIdLocal,
  output logic                       GenCal,
  output logic                       EdgeMode,
  output logic [2:0]                 EdgeDly,
  output logic [5:0]                 EdgeWidth,
  output logic                       AuxMode,
  output logic [4:0]                 AuxDly,
  output logic                       CalBusy,
  output logic [$clog2(DEPTH):0]     FifoLevel,
  output logic                       Overflow
`ifdef CAL_SCHED_STATS_EN
  ,
  output logic [15:0]                CalIssueCnt,
  output logic [7:0]                 DropCnt
`endif
);

  localparam logic [7:0] GUARD_LOAD = 8'(HOLDOFF);

  cal_sched_state_t        state;
  cal_sched_state_t        nextState;
  logic [CAL_WAIT_W-1:0]   waitCnt;
  logic [CAL_WAIT_W-1:0]   waitNext;
  logic [7:0]              guardCnt;
  logic [7:0]              guardNext;
  logic                    issue;
  logic                    accept;
  logic                    fifoEmpty;
  logic                    fifoFull;
  logic                    fifoDropped;
  cal_fields_t             fifoHead;
  cal_fields_t             heldFields;
  cal_fields_t             fieldsOut;

  assign accept = CalValid &&
                  (CalPayload[CAL_BCAST_BIT] || (CalPayload[CAL_BCAST_BIT-1 -: 3] == ChipIdLocal));

  cal_sched_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk         (clk),
    .Reset       (Reset),
    .push        (accept),
    .pop         (GenCal),
    .wrData      (cal_fields_t'(CalPayload[15:0])),
    .rdData      (fifoHead),
    .level       (FifoLevel),
    .full        (fifoFull),
    .empty       (fifoEmpty),
    .pushDropped (fifoDropped)
  );

  // State and timer registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= IDLE;
      waitCnt  <= '0;
      guardCnt <= '0;
    end else begin
      state    <= nextState;
      waitCnt  <= waitNext;
      guardCnt <= guardNext;
    end
  end

  // Next-state, timer reloads and issue decision.
  always_comb begin
    nextState = state;
    waitNext  = waitCnt;
    guardNext = guardCnt;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          issue     = 1'b1;
          waitNext  = calWaitCycles(fifoHead);
          nextState = RUN;
        end
      end
      RUN: begin
        if (waitCnt == '0) begin
          if (HOLDOFF == 0) begin
            nextState = IDLE;
          end else begin
            guardNext = GUARD_LOAD;
            nextState = GUARD;
          end
        end else begin
          waitNext = waitCnt - 7'd1;
        end
      end
      GUARD: begin
        guardNext = guardCnt - 8'd1;
        if (guardCnt <= 8'd1) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Reset in the same cycle suppresses any pending issue.
  assign GenCal  = issue && !Reset;
  assign CalBusy = (state != IDLE) || GenCal;

  // Field hold register; loads only when a command is issued.
  always_ff @(posedge clk) begin
    if (Reset) begin
      heldFields <= '0;
    end else if (GenCal) begin
      heldFields <= fifoHead;
    end
  end

  // Fields track the FIFO head in the GenCal cycle so the generator sees them with the strobe.
  assign fieldsOut = GenCal ? fifoHead : heldFields;
  assign EdgeMode  = fieldsOut.edgeMode;
  assign EdgeDly   = fieldsOut.edgeDly;
  assign EdgeWidth = fieldsOut.edgeWidth;
  assign AuxMode   = fieldsOut.auxMode;
  assign AuxDly    = fieldsOut.auxDly;

  // Sticky overflow flag.
  always_ff @(posedge clk) begin
    if (Reset) begin
      Overflow <= 1'b0;
    end else if (fifoDropped) begin
      Overflow <= 1'b1;
    end
  end

`ifdef CAL_SCHED_STATS_EN
  // Saturating issue and drop counters.
  always_ff @(posedge clk) begin
    if (Reset) begin
      CalIssueCnt <= '0;
      DropCnt     <= '0;
    end else begin
      if (GenCal && (CalIssueCnt != 16'hFFFF)) CalIssueCnt <= CalIssueCnt + 16'd1;
      if (fifoDropped && (DropCnt != 8'hFF))   DropCnt     <= DropCnt + 8'd1;
    end
  end
`endif

endmodule
